// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/decode/update sequencer.
//
// Steps each instruction through FETCH -> LOAD -> DECODE -> EXEC -> UPDATE.
// It drives the register load enables and the PC-next selects, and handshakes
// with the execute unit (exec_start / exec_done).
//
// Optional feature macro: CALL_STACK_EN
//   defined   : CALL pushes pc_in+2 onto a return stack and RET pops it.
//               Overflow or underflow moves the sequencer to ERROR.
//   undefined : there is no stack storage and ret_addr is tied to 0.
//               CALL or RET seen in DECODE moves the sequencer to ERROR.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin/resume fetching from IDLE or HALTED
//   halt_req                   stop after the current instruction retires
//   instr_in, pc_in, cond_in   opcode, current PC, branch condition
//   exec_done                  execute unit finished
//   exec_start                 one-cycle pulse launching execution
//   ctrl_reg_instr/arg/jump/pc register load enables
//   sel_pc_updater             0 = PC+1, 1 = PC+2
//   sel_mux                    00 inc PC, 01 jump abs, 10 PC+jump, 11 return
//   ret_addr                   top of return stack
//   busy, error                activity / sticky fault
module fetch_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  cond_in,
  input  logic                  exec_done,
  output logic                  exec_start,
  output logic                  ctrl_reg_instr,
  output logic                  ctrl_reg_arg,
  output logic                  ctrl_reg_jump,
  output logic                  ctrl_reg_pc,
  output logic                  sel_pc_updater,
  output logic [1:0]            sel_mux,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_UPDATE, S_HALTED, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_ONE, C_TWO, C_JMP, C_BRC, C_CALL, C_RET, C_OTHER
  } cls_t;

  state_t state, state_next;
  cls_t   cls_q, cls_dec;
  logic   exec_first;
  logic   halt_pend;
  logic   is_halt;
  logic   decode_fault;
  logic   stack_fault;

  // Opcode classification, used only in DECODE and latched for UPDATE.
  always_comb begin
    cls_dec = C_OTHER;
    unique case (instr_in[7:6])
      2'b00: cls_dec = C_ONE;
      2'b01: cls_dec = C_TWO;
      2'b10: begin
        unique case (instr_in[5:4])
          2'b00: cls_dec = C_JMP;
          2'b01: cls_dec = C_BRC;
          2'b10: cls_dec = C_CALL;
          2'b11: cls_dec = C_RET;
        endcase
      end
      2'b11: cls_dec = C_OTHER;
    endcase
  end

  assign is_halt = (instr_in[7:0] == 8'hFF);

`ifdef CALL_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       top_idx;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic                  stack_full, stack_empty, push, pop;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = sp - SP_W'(1);
  assign stack_fault = (state == S_UPDATE) &&
                       (((cls_q == C_CALL) && stack_full) ||
                        ((cls_q == C_RET) && stack_empty));
  assign push         = (state == S_UPDATE) && (cls_q == C_CALL) && !stack_full;
  assign pop          = (state == S_UPDATE) && (cls_q == C_RET) && !stack_empty;
  assign decode_fault = 1'b0;
  assign ret_addr     = stack_empty ? '0 : stack_mem[top_idx[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push) begin
      stack_mem[sp[IDX_W-1:0]] <= pc_in + ADDR_WIDTH'(2);
      sp <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end
`else
  logic unused_pc;

  assign unused_pc    = ^pc_in;
  assign stack_fault  = 1'b0;
  assign decode_fault = (state == S_DECODE) &&
                        ((cls_dec == C_CALL) || (cls_dec == C_RET));
  assign ret_addr     = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cls_q      <= C_ONE;
      exec_first <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      state      <= state_next;
      exec_first <= (state_next == S_EXEC) && (state != S_EXEC);
      if (state == S_DECODE)
        cls_q <= cls_dec;
      // A halt request seen outside UPDATE waits here until UPDATE consumes it.
      if (state == S_UPDATE)
        halt_pend <= 1'b0;
      else if (halt_req)
        halt_pend <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    exec_start     = 1'b0;
    ctrl_reg_instr = 1'b0;
    ctrl_reg_arg   = 1'b0;
    ctrl_reg_jump  = 1'b0;
    ctrl_reg_pc    = 1'b0;
    sel_pc_updater = 1'b0;
    sel_mux        = 2'b00;
    unique case (state)
      S_IDLE, S_HALTED: if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        ctrl_reg_instr = 1'b1;
        ctrl_reg_arg   = 1'b1;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt) begin
          state_next = S_HALTED;
        end else if (decode_fault) begin
          state_next = S_ERROR;
        end else begin
          ctrl_reg_jump = (cls_dec == C_JMP) || (cls_dec == C_BRC) ||
                          (cls_dec == C_CALL);
          state_next    = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_start = exec_first;
        if (exec_done) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        if (stack_fault) begin
          state_next = S_ERROR;
        end else begin
          ctrl_reg_pc = 1'b1;
          unique case (cls_q)
            C_TWO:          sel_pc_updater = 1'b1;
            C_JMP, C_CALL:  sel_mux = 2'b01;
            C_RET:          sel_mux = 2'b11;
            C_BRC: begin
              if (cond_in) sel_mux = 2'b10;
              else         sel_pc_updater = 1'b1;
            end
            default: ;
          endcase
          state_next = (halt_req || halt_pend) ? S_HALTED : S_FETCH;
        end
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy  = !((state == S_IDLE) || (state == S_HALTED) || (state == S_ERROR));
  assign error = (state == S_ERROR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default parameters).
// Stack behaviour is exercised when CALL_STACK_EN is defined; otherwise the
// bench expects CALL to fault in DECODE.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, cond_in, exec_done;
  logic [7:0]  instr_in;
  logic [11:0] pc_in;
  logic        exec_start, ctrl_reg_instr, ctrl_reg_arg, ctrl_reg_jump, ctrl_reg_pc;
  logic        sel_pc_updater, busy, error;
  logic [1:0]  sel_mux;
  logic [11:0] ret_addr;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .instr_in(instr_in), .pc_in(pc_in), .cond_in(cond_in), .exec_done(exec_done),
    .exec_start(exec_start), .ctrl_reg_instr(ctrl_reg_instr),
    .ctrl_reg_arg(ctrl_reg_arg), .ctrl_reg_jump(ctrl_reg_jump),
    .ctrl_reg_pc(ctrl_reg_pc), .sel_pc_updater(sel_pc_updater),
    .sel_mux(sel_mux), .ret_addr(ret_addr), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all control outputs: {exec_start, instr, arg, jump, pc, pu, mux, busy, error}
  task automatic chk(input string tag, input logic es, input logic ld, input logic rj,
                     input logic rpc, input logic pu, input logic [1:0] mux,
                     input logic bsy, input logic err);
    logic [9:0] obs, exp;
    exp = {es, ld, ld, rj, rpc, pu, mux, bsy, err};
    obs = {exec_start, ctrl_reg_instr, ctrl_reg_arg, ctrl_reg_jump, ctrl_reg_pc,
           sel_pc_updater, sel_mux, busy, error};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [11:0] exp);
    checks++;
    assert (ret_addr === exp) else begin
      failures++;
      $error("FAIL %s ret_addr observed=%h expected=%h", tag, ret_addr, exp);
    end
  endtask

  // Called with the DUT in FETCH and exec_done=1; returns with the DUT in the
  // next FETCH. Checks each of the five states of one instruction.
  task automatic do_instr(input string tag, input logic rj, input logic pu,
                          input logic [1:0] mux);
    chk({tag, "_fetch"}, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk({tag, "_load"}, 0, 1, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk({tag, "_decode"}, 0, 0, rj, 0, 0, 2'b00, 1, 0);
    tick();
    chk({tag, "_exec"}, 1, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk({tag, "_update"}, 0, 0, 0, 1, pu, mux, 1, 0);
    tick();
  endtask

  initial begin
    reset = 1; start = 0; halt_req = 0; cond_in = 0; exec_done = 0;
    instr_in = 8'h00; pc_in = 12'h000;
    tick();
    tick();
    chk("reset", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    chk_ret("reset", 12'h000);

    reset = 0; start = 1; instr_in = 8'h05; exec_done = 1;
    tick();
    do_instr("one_a", 0, 0, 2'b00);
    do_instr("one_b", 0, 0, 2'b00);
    instr_in = 8'h45;
    do_instr("two", 0, 1, 2'b00);
    instr_in = 8'h90; cond_in = 1;
    do_instr("brc_t", 1, 0, 2'b10);
    cond_in = 0;
    do_instr("brc_nt", 1, 1, 2'b00);
    instr_in = 8'h80;
    do_instr("jmp", 1, 0, 2'b01);
    instr_in = 8'hC3;
    do_instr("other", 0, 0, 2'b00);

    // halt_req pulsed in EXEC, exec_done three cycles late
    instr_in = 8'h05; exec_done = 0;
    tick(); tick();
    tick();
    chk("hlt_exec1", 1, 0, 0, 0, 0, 2'b00, 1, 0);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("hlt_exec2", 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk("hlt_exec3", 0, 0, 0, 0, 0, 2'b00, 1, 0);
    exec_done = 1;
    tick();
    chk("hlt_update", 0, 0, 0, 1, 0, 2'b00, 1, 0);
    start = 0;
    tick();
    chk("halted", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    chk("halted_hold", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    start = 1;
    tick();
    chk("resume_fetch", 0, 0, 0, 0, 0, 2'b00, 1, 0);

    // HALT opcode skips EXEC
    instr_in = 8'hFF;
    tick(); tick();
    chk("hop_decode", 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk("hop_halted", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    chk("hop_fetch", 0, 0, 0, 0, 0, 2'b00, 1, 0);

    // halt request pending at reset is discarded; reset aborts EXEC
    instr_in = 8'h05; exec_done = 0;
    tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    chk("rst_exec", 1, 0, 0, 0, 0, 2'b00, 1, 0);
    reset = 1; exec_done = 1;
    tick();
    chk("rst_idle", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    reset = 0; start = 0;
    tick();
    chk("rst_idle_hold", 0, 0, 0, 0, 0, 2'b00, 0, 0);
    start = 1;
    tick();
    do_instr("no_stale", 0, 0, 2'b00);
    chk("no_stale_halt", 0, 0, 0, 0, 0, 2'b00, 1, 0);

`ifdef CALL_STACK_EN
    instr_in = 8'hA0; pc_in = 12'h0FF;
    do_instr("call", 1, 0, 2'b01);
    chk_ret("after_push", 12'h101);
    instr_in = 8'hB0;
    do_instr("ret", 0, 0, 2'b11);
    chk_ret("after_pop", 12'h000);
    instr_in = 8'hA0;
    for (int i = 0; i < 8; i++) begin
      pc_in = 12'(i);
      do_instr($sformatf("nest%0d", i), 1, 0, 2'b01);
    end
    chk_ret("full_top", 12'h009);
    pc_in = 12'h100;
    tick(); tick();
    chk("ovf_decode", 0, 0, 1, 0, 0, 2'b00, 1, 0);
    tick();
    chk("ovf_exec", 1, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk("ovf_update", 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk("ovf_error", 0, 0, 0, 0, 0, 2'b00, 0, 1);
    chk_ret("ovf_unchanged", 12'h009);
    tick();
    chk("ovf_sticky", 0, 0, 0, 0, 0, 2'b00, 0, 1);
`else
    instr_in = 8'hA0;
    tick(); tick();
    chk("call_decode", 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tick();
    chk("call_error", 0, 0, 0, 0, 0, 2'b00, 0, 1);
    tick();
    chk("error_sticky", 0, 0, 0, 0, 0, 2'b00, 0, 1);
    chk_ret("no_stack", 12'h000);
`endif

    reset = 1;
    tick();
    reset = 0; start = 0;
    chk("error_cleared", 0, 0, 0, 0, 0, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, instruction/argument byte width; ADDR_WIDTH, default 12, program address width; STACK_DEPTH, default 8, return-stack entries (power of two).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level; begin or resume fetching from IDLE or HALTED.
REQ-005 halt_req  input  1  stop after the current instruction retires.
REQ-006 instr_in  input  DATA_WIDTH  current opcode from the instruction register.
REQ-007 pc_in  input  ADDR_WIDTH  current program counter value.
REQ-008 cond_in  input  1  branch condition from the execute unit.
REQ-009 exec_done  input  1  execute unit finished the current instruction.
REQ-010 exec_start  output  1  one-cycle pulse launching execution.
REQ-011 ctrl_reg_instr, ctrl_reg_arg, ctrl_reg_jump, ctrl_reg_pc  output  1 each  register load enables.
REQ-012 sel_pc_updater  output  1  0 = PC+1, 1 = PC+2.
REQ-013 sel_mux  output  2  00 incremented PC, 01 jump absolute, 10 PC+jump, 11 return address.
REQ-014 ret_addr  output  ADDR_WIDTH  top of return stack.
REQ-015 busy  output  1  high in every state except IDLE, HALTED, ERROR.
REQ-016 error  output  1  sticky fault flag.

Function
REQ-017 States SHALL be IDLE, FETCH, LOAD, DECODE, EXEC, UPDATE, HALTED, ERROR.
REQ-018 IDLE/HALTED -> FETCH when start=1; otherwise hold.
REQ-019 FETCH SHALL last one cycle with all enables low, covering synchronous memory read latency.
REQ-020 LOAD SHALL assert ctrl_reg_instr and ctrl_reg_arg for one cycle, then go to DECODE.
REQ-021 DECODE SHALL classify instr_in[7:6]: 00 one-byte (PC+1); 01 two-byte (PC+2); 10 branch, subtype instr_in[5:4]: 00 JMP, 01 BRC, 10 CALL, 11 RET; 11 other. Opcode 8'hFF SHALL be HALT.
REQ-022 DECODE SHALL assert ctrl_reg_jump for one cycle for JMP, BRC and CALL, then go to EXEC.
REQ-023 EXEC entry SHALL pulse exec_start for exactly one cycle; EXEC SHALL wait for exec_done, which may arrive in the pulse cycle.
REQ-024 UPDATE SHALL assert ctrl_reg_pc for one cycle with these selects: one-byte/other sel_mux=00, sel_pc_updater=0; two-byte sel_mux=00, sel_pc_updater=1; JMP sel_mux=01; BRC sel_mux=10 if cond_in=1, else 00 with sel_pc_updater=1; CALL sel_mux=01; RET sel_mux=11.
REQ-025 CALL in UPDATE SHALL push pc_in+2 (mod 2^ADDR_WIDTH). RET SHALL pop; ret_addr SHALL present the top entry combinationally.
REQ-026 HALT SHALL skip EXEC and go DECODE -> HALTED without loading the PC.
REQ-027 UPDATE -> HALTED if halt_req=1 in that cycle; otherwise -> FETCH. halt_req in any other state SHALL be held pending until UPDATE.
REQ-028 Minimum throughput SHALL be 5 cycles per instruction (FETCH, LOAD, DECODE, EXEC with same-cycle done, UPDATE).
REQ-029 Push on full or pop on empty SHALL go to ERROR, set error=1, suppress ctrl_reg_pc and leave the stack unchanged. ERROR SHALL be left only by reset.
REQ-030 Only one of ctrl_reg_instr/arg, ctrl_reg_jump or ctrl_reg_pc SHALL be asserted in any given cycle.

Reset
REQ-031 On reset, the state SHALL become IDLE and stack pointer 0.
REQ-032 On reset, all outputs SHALL be 0, ret_addr SHALL be 0, and any pending halt SHALL be cleared.
REQ-033 Reset SHALL take priority over start and exec_done and SHALL abort any state mid-instruction.

Configuration
REQ-034 With CALL_STACK_EN defined, CALL/RET SHALL behave per REQ-024, REQ-025 and REQ-029.
REQ-035 Without CALL_STACK_EN, no stack storage SHALL exist and ret_addr SHALL be tied to 0. CALL or RET decoded in DECODE SHALL go to ERROR and set error=1.

Verification
REQ-036 Reset, start=1, one-byte opcode 8'h05, exec_done tied 1 -> ctrl_reg_pc with sel_mux=00, sel_pc_updater=0 every 5 cycles.
REQ-037 Opcode 8'h45 -> UPDATE drives sel_pc_updater=1; ctrl_reg_jump never asserts.
REQ-038 BRC 8'h90 with cond_in=1, then cond_in=0 -> sel_mux=10, then sel_mux=00 with sel_pc_updater=1.
REQ-039 CALL at pc_in=12'h0FF, then RET -> ret_addr=12'h101 after the push, RET UPDATE sel_mux=11; a 9th nested CALL with depth 8 -> error=1, state ERROR.
REQ-040 halt_req pulsed during EXEC, exec_done delayed 3 cycles -> PC still loaded, then HALTED with busy=0; start=1 -> FETCH.
REQ-041 Reset asserted during EXEC -> next cycle IDLE, all outputs 0, pending exec_done ignored.
